// File: rtl/apb_table_bridge_pkg.sv
// Shared types and sizing helpers for the APB table bridge.
package apb_table_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_DONE = 2'd2
    } bridge_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADD_C0DE;

    function automatic int words_per_entry(input int data_w);
        return (data_w + 31) / 32;
    endfunction

    function automatic int entry_stride(input int data_w);
        return 1 << $clog2(words_per_entry(data_w));
    endfunction

endpackage

// File: rtl/apb_table_bridge.sv
// APB window onto a wide single-port table: a write shadow commits whole entries,
// a read snapshot keeps multi-word reads of one entry coherent.
`ifndef ATB_DFF
`define ATB_DFF(q, d, rv) \
    always_ff @(posedge clk or negedge rst_n) \
        if (!rst_n) q <= (rv); \
        else q <= (d);
`endif

// state      | meaning
// ST_IDLE    | accepts APB accesses; writes, errors and snapshot hits complete here
// ST_RD_WAIT | fetch issued, counting down the memory read latency
// ST_RD_DONE | snapshot captured, read word returned
module apb_table_bridge
    import apb_table_bridge_pkg::*;
#(
    parameter int          DATA_W        = 37,
    parameter int          DEPTH         = 10,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          RD_LAT        = 1,
    parameter bit          APB_READY_1WS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              paddr,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic                     mem_enable,
    output logic                     mem_wr_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int          WPE       = words_per_entry(DATA_W);
    localparam int          STRIDE    = entry_stride(DATA_W);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam int          WW        = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int          CNT_W     = $clog2(RD_LAT + 1);
    localparam int          SH_W      = WPE * 32;
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * STRIDE * 4);

    bridge_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]     word_q, word_d;
    logic [SH_W-1:0]   wsh_q, wsh_d, rsh_q, rsh_d;
    logic              rvalid_q, rvalid_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_rdy_q, rsp_err_q;
    logic [31:0]       rsp_data_q;

    logic              rsp_vld, rsp_err;
    logic [31:0]       rsp_data;
    logic [31:0]       rel, off, word, rd_sel, rd_word;
    logic [IDX_W-1:0]  idx;
    logic              in_range, dec_err, is_last, need_fetch, access;
    logic [SH_W-1:0]   wsh_new;

    always_comb begin
        rel        = paddr - BASE_ADDR;
        off        = rel >> 2;
        word       = off % STRIDE;
        idx        = IDX_W'(off / STRIDE);
        in_range   = (paddr >= BASE_ADDR) && (rel < WIN_BYTES);
        dec_err    = !in_range || (word >= 32'(WPE));
        is_last    = (word == 32'(WPE - 1));
        need_fetch = (word == '0) || !rvalid_q || (ridx_q != idx);
        // with a wait state the access phase is still up while the response is out
        access     = psel && penable && (state_q == ST_IDLE) && !(APB_READY_1WS && rsp_rdy_q);
    end

    always_comb begin
        wsh_new = wsh_q;
        rd_word = '0;
        rd_sel  = (state_q == ST_RD_DONE) ? 32'(word_q) : word;
        for (int w = 0; w < WPE; w++) begin
            if (word == 32'(w)) wsh_new[w*32 +: 32] = pwdata;
            if (rd_sel == 32'(w)) rd_word = rsh_q[w*32 +: 32];
        end
    end

    `ATB_DFF(state_q, state_d, ST_IDLE)

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (access && !pwrite && !dec_err && need_fetch) state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (cnt_q == '0) state_d = ST_RD_DONE;
            ST_RD_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wsh_d    = wsh_q;
        rsh_d    = rsh_q;
        rvalid_d = rvalid_q;
        ridx_d   = ridx_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        rsp_vld  = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (dec_err) begin
                        rsp_vld  = 1'b1;
                        rsp_err  = 1'b1;
                        rsp_data = pwrite ? 32'h0 : ERR_RDATA;
                    end else if (pwrite) begin
                        rsp_vld = 1'b1;
                        wsh_d   = wsh_new;
                        if (is_last) begin
                            mem_en_d = 1'b1;
                            mem_wr_d = 1'b1;
                            addr_d   = idx;
                            wdata_d  = wsh_new[DATA_W-1:0];
                            if (rvalid_q && (ridx_q == idx)) rvalid_d = 1'b0;
                        end
                    end else if (need_fetch) begin
                        mem_en_d = 1'b1;
                        addr_d   = idx;
                        word_d   = WW'(word);
                        cnt_d    = CNT_W'(RD_LAT);
                    end else begin
                        rsp_vld  = 1'b1;
                        rsp_data = rd_word;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    rsh_d    = SH_W'(mem_rdata);
                    ridx_d   = addr_q;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RD_DONE: begin
                rsp_vld  = 1'b1;
                rsp_data = rd_word;
            end
            default: ;
        endcase
    end

    `ATB_DFF(cnt_q, cnt_d, '0)
    `ATB_DFF(word_q, word_d, '0)
    `ATB_DFF(wsh_q, wsh_d, '0)
    `ATB_DFF(rsh_q, rsh_d, '0)
    `ATB_DFF(rvalid_q, rvalid_d, 1'b0)
    `ATB_DFF(ridx_q, ridx_d, '0)
    `ATB_DFF(mem_en_q, mem_en_d, 1'b0)
    `ATB_DFF(mem_wr_q, mem_wr_d, 1'b0)
    `ATB_DFF(addr_q, addr_d, '0)
    `ATB_DFF(wdata_q, wdata_d, '0)
    `ATB_DFF(rsp_rdy_q, rsp_vld, 1'b0)
    `ATB_DFF(rsp_err_q, rsp_err, 1'b0)
    `ATB_DFF(rsp_data_q, rsp_data, '0)

    assign pready     = APB_READY_1WS ? rsp_rdy_q  : rsp_vld;
    assign prdata     = APB_READY_1WS ? rsp_data_q : rsp_data;
    assign pslverr    = APB_READY_1WS ? rsp_err_q  : rsp_err;
    assign mem_enable = mem_en_q;
    assign mem_wr_en  = mem_wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_table_bridge.sv
// Bench for apb_table_bridge: three configurations on one shared APB bus, scoreboarded.
module tb_apb_table_bridge;
    import apb_table_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    int          sel = 0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    bit          init_done = 1'b0;

    logic [31:0] prdata_a [3];
    logic        pready_a [3];
    logic        pslverr_a [3];
    logic        men_a [3];
    logic        mwe_a [3];
    logic [3:0]  maddr_a [3];
    logic [36:0] mwd0, mwd2, mrd0, mrd2;
    logic [69:0] mwd1;
    logic [69:0] mrd1 = '0;

    apb_table_bridge #(.DATA_W(37), .DEPTH(10), .BASE_ADDR(32'h0), .RD_LAT(2), .APB_READY_1WS(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .psel(psel && sel == 0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[0]), .pready(pready_a[0]),
        .pslverr(pslverr_a[0]), .mem_enable(men_a[0]), .mem_wr_en(mwe_a[0]),
        .mem_addr(maddr_a[0]), .mem_wdata(mwd0), .mem_rdata(mrd0));

    apb_table_bridge #(.DATA_W(70), .DEPTH(10), .BASE_ADDR(32'h0), .RD_LAT(1), .APB_READY_1WS(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .psel(psel && sel == 1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[1]), .pready(pready_a[1]),
        .pslverr(pslverr_a[1]), .mem_enable(men_a[1]), .mem_wr_en(mwe_a[1]),
        .mem_addr(maddr_a[1]), .mem_wdata(mwd1), .mem_rdata(mrd1));

    apb_table_bridge #(.DATA_W(37), .DEPTH(10), .BASE_ADDR(32'h0), .RD_LAT(2), .APB_READY_1WS(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .psel(psel && sel == 2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a[2]), .pready(pready_a[2]),
        .pslverr(pslverr_a[2]), .mem_enable(men_a[2]), .mem_wr_en(mwe_a[2]),
        .mem_addr(maddr_a[2]), .mem_wdata(mwd2), .mem_rdata(mrd2));

    // Table memories: entry i preloads to {i+16, 32'hC0DE0000+i}, read latency 2.
    logic [36:0] mem0 [10];
    logic [36:0] mem2 [10];
    logic [36:0] r0a, r0b, r2a, r2b;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 10; i++) begin
                mem0[i] <= {5'(i + 16), 32'hC0DE0000 | 32'(i)};
                mem2[i] <= {5'(i + 16), 32'hC0DE0000 | 32'(i)};
            end
        end else begin
            if (men_a[0] && mwe_a[0]) mem0[maddr_a[0]] <= mwd0;
            if (men_a[2] && mwe_a[2]) mem2[maddr_a[2]] <= mwd2;
        end
        if (men_a[0] && !mwe_a[0]) r0a <= mem0[maddr_a[0]];
        if (men_a[2] && !mwe_a[2]) r2a <= mem2[maddr_a[2]];
        r0b <= r0a;
        r2b <= r2a;
    end
    assign mrd0 = r0b;
    assign mrd2 = r2b;

    logic [31:0]  prdata_m;
    logic         pready_m, pslverr_m, men_m, mwe_m;
    logic [3:0]   maddr_m;
    logic [127:0] mwd_m;
    always_comb begin
        prdata_m  = prdata_a[sel];
        pready_m  = pready_a[sel];
        pslverr_m = pslverr_a[sel];
        men_m     = men_a[sel];
        mwe_m     = mwe_a[sel];
        maddr_m   = maddr_a[sel];
        case (sel)
            1:       mwd_m = 128'(mwd1);
            2:       mwd_m = 128'(mwd2);
            default: mwd_m = 128'(mwd0);
        endcase
    end

    typedef struct { int cyc; logic [31:0] data; logic err; } rsp_t;
    typedef struct { int cyc; logic we; logic [3:0] addr; logic [127:0] wd; } mev_t;
    rsp_t rsp_q [$];
    mev_t mem_q [$];

    always @(negedge clk) begin
        if (rst_n && pready_m) begin
            n_vec++;
            if (rsp_q.size() == 0) begin
                n_err++;
                $display("FAIL apb_spurious dut%0d cyc=%0d pready with no expected response", sel, cyc);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                if (cyc != e.cyc || prdata_m != e.data || pslverr_m != e.err) begin
                    n_err++;
                    $display("FAIL apb_rsp dut%0d got cyc=%0d prdata=%h pslverr=%0d, required cyc=%0d prdata=%h pslverr=%0d",
                             sel, cyc, prdata_m, pslverr_m, e.cyc, e.data, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && men_m) begin
            n_vec++;
            if (mem_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_spurious dut%0d cyc=%0d we=%0d addr=%0d with no expected access", sel, cyc, mwe_m, maddr_m);
            end else begin
                mev_t e;
                e = mem_q.pop_front();
                if (cyc != e.cyc || mwe_m != e.we || maddr_m != e.addr || (e.we && mwd_m != e.wd)) begin
                    n_err++;
                    $display("FAIL mem_access dut%0d got cyc=%0d we=%0d addr=%0d wdata=%h, required cyc=%0d we=%0d addr=%0d wdata=%h",
                             sel, cyc, mwe_m, maddr_m, mwd_m, e.cyc, e.we, e.addr, e.wd);
                end
            end
        end
    end

    task automatic apb(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] rdata, input bit err,
                       input bit mem, input bit mwe, input logic [3:0] maddr, input logic [127:0] mwd);
        bit got;
        @(posedge clk); #1;
        sel = k; psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        rsp_q.push_back('{cyc + lat, rdata, err});
        if (mem) mem_q.push_back('{cyc + 1, mwe, maddr, mwd});
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = pready_m;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL apb_timeout dut%0d addr=%h no pready within 16 cycles, required pready", k, a);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        logic [2:0] nz;
        nz[0] = |{prdata_a[0], pready_a[0], pslverr_a[0], men_a[0], mwe_a[0], maddr_a[0], mwd0};
        nz[1] = |{prdata_a[1], pready_a[1], pslverr_a[1], men_a[1], mwe_a[1], maddr_a[1], mwd1};
        nz[2] = |{prdata_a[2], pready_a[2], pslverr_a[2], men_a[2], mwe_a[2], maddr_a[2], mwd2};
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (nz[k]) begin
                n_err++;
                $display("FAIL %s dut%0d outputs nonzero, required all 0", tag, k);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        init_done = 1'b1;
        check_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // DATA_W 37, RD_LAT 2: commits, fetch, snapshot hit, errors, coherency
        apb(0, 1, 32'h00, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0, 0, 0);
        apb(0, 1, 32'h04, 32'h0000001F, 0, 32'h0, 0, 1, 1, 0, 128'h1F_DEADBEEF);
        apb(0, 1, 32'h08, 32'h12345678, 0, 32'h0, 0, 0, 0, 0, 0);
        apb(0, 1, 32'h0C, 32'hFFFFFFE5, 0, 32'h0, 0, 1, 1, 1, 128'h05_12345678);
        apb(0, 0, 32'h18, 32'h0,        4, 32'hC0DE0003, 0, 1, 0, 3, 0);
        apb(0, 0, 32'h1C, 32'h0,        0, 32'h00000013, 0, 0, 0, 0, 0);
        apb(0, 0, 32'h50, 32'h0,        0, 32'hBADDC0DE, 1, 0, 0, 0, 0);
        apb(0, 1, 32'h50, 32'h1,        0, 32'h0,        1, 0, 0, 0, 0);
        apb(0, 0, 32'h4C, 32'h0,        4, 32'h00000019, 0, 1, 0, 9, 0);
        apb(0, 0, 32'h18, 32'h0,        4, 32'hC0DE0003, 0, 1, 0, 3, 0);
        apb(0, 1, 32'h18, 32'hAAAA5555, 0, 32'h0, 0, 0, 0, 0, 0);
        apb(0, 1, 32'h1C, 32'h0000000A, 0, 32'h0, 0, 1, 1, 3, 128'h0A_AAAA5555);
        apb(0, 0, 32'h1C, 32'h0,        4, 32'h0000000A, 0, 1, 0, 3, 0);
        apb(0, 0, 32'h1C, 32'h0,        0, 32'h0000000A, 0, 0, 0, 0, 0);
        apb(0, 0, 32'h00, 32'h0,        4, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        apb(0, 0, 32'h04, 32'h0,        0, 32'h0000001F, 0, 0, 0, 0, 0);

        // DATA_W 70: three words per entry, stride 4
        apb(1, 1, 32'h00, 32'h11111111, 0, 32'h0, 0, 0, 0, 0, 0);
        apb(1, 1, 32'h04, 32'h22222222, 0, 32'h0, 0, 0, 0, 0, 0);
        apb(1, 1, 32'h08, 32'hFFFFFFFF, 0, 32'h0, 0, 1, 1, 0, 128'h3F_22222222_11111111);
        apb(1, 1, 32'h0C, 32'h00000005, 0, 32'h0, 1, 0, 0, 0, 0);
        apb(1, 0, 32'h1C, 32'h0,        0, 32'hBADDC0DE, 1, 0, 0, 0, 0);
        apb(1, 0, 32'hA0, 32'h0,        0, 32'hBADDC0DE, 1, 0, 0, 0, 0);

        // one wait state
        apb(2, 0, 32'h18, 32'h0,        5, 32'hC0DE0003, 0, 1, 0, 3, 0);
        apb(2, 0, 32'h1C, 32'h0,        1, 32'h00000013, 0, 0, 0, 0, 0);
        apb(2, 1, 32'h50, 32'h1,        1, 32'h0,        1, 0, 0, 0, 0);
        apb(2, 1, 32'h2C, 32'h00000007, 1, 32'h0,        0, 1, 1, 5, 128'h07_00000000);

        // reset while waiting on the memory
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; pwrite = 1'b0; paddr = 32'h30; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        mem_q.push_back('{cyc + 1, 1'b0, 4'd6, 128'h0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("midread_reset");
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apb(0, 0, 32'h34, 32'h0,        4, 32'h00000016, 0, 1, 0, 6, 0);

        repeat (5) @(posedge clk);
        n_vec++;
        if (rsp_q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_drain %0d responses outstanding, required 0", rsp_q.size());
        end
        n_vec++;
        if (mem_q.size() != 0) begin
            n_err++;
            $display("FAIL mem_drain %0d memory accesses outstanding, required 0", mem_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
